// File: rtl/projeto_final_pkg.sv
// Shared constants and state encoding for the
// Horner-form polynomial evaluator.
package projeto_final_pkg;

  localparam int P_W    = 16;
  localparam int P_KW   = 8;
  localparam int NSTEP  = P_KW / 2;
  localparam int STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL1 = 3'd1,
    ADD1 = 3'd2,
    MUL2 = 3'd3,
    ADD2 = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/projeto_final_mul_step_r4.sv
// One radix-4 shift-add step:
// acc + (mcand * digit << shift), mod 2^W.
module mul_step_r4 #(
  parameter int W   = 16,
  parameter int SHW = 3
) (
  input  logic [W-1:0]   acc_i,
  input  logic [W-1:0]   mcand_i,
  input  logic [1:0]     digit_i,
  input  logic [SHW-1:0] shift_i,
  output logic [W-1:0]   acc_o
);

  logic [W-1:0] digit_ext;
  logic [W-1:0] prod;

  // Partial product, shifted into place and accumulated
  always_comb begin
    digit_ext = {{(W-2){1'b0}}, digit_i};
    prod      = mcand_i * digit_ext;
    acc_o     = acc_i + (prod << shift_i);
  end

endmodule

// File: rtl/projeto_final.sv
// Polynomial evaluator A*K^2 + B*K + C (mod 2^W)
// via Horner form on a shared radix-4 multiplier.
module projeto_final
  import projeto_final_pkg::*;
#(
  parameter int W  = P_W,
  parameter int KW = P_KW
) (
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  input  logic [W-1:0]  C,
  input  logic [KW-1:0] K,
  input  logic          inicio,
  input  logic          clk,
  input  logic          rst,
  output logic          pronto,
  output logic [W-1:0]  resultado
);

  localparam int NS  = KW / 2;
  localparam int SW  = (NS > 1) ? $clog2(NS) : 1;
  localparam int SHW = SW + 1;
  localparam logic [SW-1:0] LAST = SW'(NS - 1);

  state_t state_q, state_d;

  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  c_q, c_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [SW-1:0] step_q, step_d;
  logic          pronto_q, pronto_d;
  logic [W-1:0]  res_q, res_d;

  logic [SHW-1:0] shift;
  logic [1:0]     digit;
  logic [W-1:0]   mul_out;
  logic           last_step;

  assign shift     = {step_q, 1'b0};
  assign digit     = k_q[shift +: 2];
  assign last_step = (step_q == LAST);

  mul_step_r4 #(
    .W   (W),
    .SHW (SHW)
  ) u_mul (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .digit_i (digit),
    .shift_i (shift),
    .acc_o   (mul_out)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (inicio)    state_d = MUL1;
      MUL1: if (last_step) state_d = ADD1;
      ADD1:                state_d = MUL2;
      MUL2: if (last_step) state_d = ADD2;
      ADD2:                state_d = DONE;
      DONE: if (!inicio)   state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // Datapath and output next values per state
  always_comb begin
    b_d      = b_q;
    c_d      = c_q;
    k_d      = k_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    step_d   = step_q;
    pronto_d = pronto_q;
    res_d    = res_q;
    unique case (state_q)
      IDLE: begin
        if (inicio) begin
          b_d     = B;
          c_d     = C;
          k_d     = K;
          acc_d   = '0;
          mcand_d = A;
          step_d  = '0;
        end
      end
      MUL1, MUL2: begin
        acc_d  = mul_out;
        step_d = last_step ? '0 : step_q + 1'b1;
      end
      ADD1: begin
        mcand_d = acc_q + b_q;
        acc_d   = '0;
        step_d  = '0;
      end
      ADD2: begin
        res_d    = acc_q + c_q;
        pronto_d = 1'b1;
      end
      DONE: begin
        if (!inicio) pronto_d = 1'b0;
      end
      default: begin
        pronto_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q      <= '0;
      c_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      step_q   <= '0;
      pronto_q <= 1'b0;
      res_q    <= '0;
    end else begin
      b_q      <= b_d;
      c_q      <= c_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      step_q   <= step_d;
      pronto_q <= pronto_d;
      res_q    <= res_d;
    end
  end

  assign pronto    = pronto_q;
  assign resultado = res_q;

endmodule

// File: tb/tb_projeto_final.sv
// Randomized self-checking bench for projeto_final
// against an arithmetic polynomial model.
module tb_projeto_final;

  logic [15:0] A, B, C;
  logic [7:0]  K;
  logic        inicio;
  logic        clk;
  logic        rst;
  logic        pronto;
  logic [15:0] resultado;

  int n_checks;
  int n_fail;

  projeto_final dut (
    .A         (A),
    .B         (B),
    .C         (C),
    .K         (K),
    .inicio    (inicio),
    .clk       (clk),
    .rst       (rst),
    .pronto    (pronto),
    .resultado (resultado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] poly(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [15:0] c,
    input logic [7:0]  k
  );
    longint unsigned r;
    r = longint'(a) * longint'(k) * longint'(k)
      + longint'(b) * longint'(k)
      + longint'(c);
    return r[15:0];
  endfunction

  // Start a run and count edges after E0 until pronto.
  task automatic do_run(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [7:0]  k,
    input  bit          scramble,
    output int          lat
  );
    @(negedge clk);
    A = a; B = b; C = c; K = k;
    inicio = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (scramble) begin
        A = 16'($urandom);
        B = 16'($urandom);
        C = 16'($urandom);
        K = 8'($urandom);
      end
      if (pronto) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic drop_inicio();
    @(negedge clk);
    inicio = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    inicio = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (pronto !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pronto got %b exp 0", pronto);
    end
    n_checks++;
    if (resultado !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_res got %h exp 0000", resultado);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_run(
    input string       nm,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [15:0] c,
    input logic [7:0]  k,
    input bit          scramble
  );
    int lat;
    logic [15:0] exp_r;
    exp_r = poly(a, b, c, k);
    do_run(a, b, c, k, scramble, lat);
    n_checks++;
    if (lat != 10) begin
      n_fail++;
      $display("FAIL %s_latency got %0d exp 10", nm, lat);
    end
    n_checks++;
    if (resultado !== exp_r) begin
      n_fail++;
      $display("FAIL %s_result got %h exp %h", nm, resultado, exp_r);
    end
    drop_inicio();
    n_checks++;
    if (pronto !== 1'b0 || resultado !== exp_r) begin
      n_fail++;
      $display("FAIL %s_release got pronto=%b res=%h exp 0 %h",
               nm, pronto, resultado, exp_r);
    end
  endtask

  task automatic test_directed();
    check_run("d_101", 16'd5, 16'd3, 16'd9, 8'd4, 1'b0);
    check_run("d_230", 16'd3, 16'd4, 16'd6, 8'd8, 1'b1);
    check_run("d_k0", 16'd7, 16'd7, 16'd42, 8'd0, 1'b0);
    check_run("d_wrap", 16'hFFFF, 16'd0, 16'd0, 8'd255, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      check_run("rnd", 16'($urandom), 16'($urandom),
                16'($urandom), 8'($urandom),
                bit'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_handshake();
    int lat;
    int bad;
    logic [15:0] exp_r;
    exp_r = poly(16'd11, 16'd22, 16'd33, 8'd9);
    do_run(16'd11, 16'd22, 16'd33, 8'd9, 1'b0, lat);
    n_checks++;
    if (resultado !== exp_r) begin
      n_fail++;
      $display("FAIL hs_result got %h exp %h", resultado, exp_r);
    end
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (pronto !== 1'b1 || resultado !== exp_r) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hs_hold got %0d bad cycles exp 0", bad);
    end
    drop_inicio();
    n_checks++;
    if (pronto !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_drop got pronto=%b exp 0", pronto);
    end
    check_run("hs_again", 16'd100, 16'd200, 16'd300, 8'd17, 1'b0);
  endtask

  task automatic test_reset_midrun();
    int bad;
    @(negedge clk);
    A = 16'd1234; B = 16'd77; C = 16'd5; K = 8'd201;
    inicio = 1'b1;
    @(posedge clk);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    inicio = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (pronto !== 1'b0 || resultado !== 16'h0) begin
      n_fail++;
      $display("FAIL midrst got pronto=%b res=%h exp 0 0000",
               pronto, resultado);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (pronto !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL midrst_idle got %0d pronto cycles exp 0", bad);
    end
    check_run("midrst_again", 16'd1234, 16'd77, 16'd5, 8'd201, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 5; n++) begin
      check_run("b2b", 16'($urandom), 16'($urandom),
                16'($urandom), 8'($urandom), 1'b0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst    = 1'b0;
    inicio = 1'b0;
    A = '0; B = '0; C = '0; K = '0;
    test_reset();
    test_directed();
    test_random();
    test_handshake();
    test_reset_midrun();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
